// File: rtl/mixer_pkg.sv
// Shared definitions for the sample mixer: FSM encoding, LFSR seed/taps and
// the Q-format unity-gain helper.
package mixer_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_NOISE = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ACCUM = ST_ACCUM,
        S_NOISE = ST_NOISE,
        S_OUT   = ST_OUT
    } state_t;

    // Noise LFSR: x^16+x^15+x^13+x^4, Fibonacci, shift left
    localparam logic [15:0]     LFSR_SEED  = 16'h0305;
    localparam int unsigned     LFSR_TAP_A = 15;
    localparam int unsigned     LFSR_TAP_B = 14;
    localparam int unsigned     LFSR_TAP_C = 12;
    localparam int unsigned     LFSR_TAP_D = 3;

    // Unity gain for an unsigned Q1.(gw-1) gain word
    function automatic int unsigned unity_gain(input int unsigned gw);
        return 32'(1) << (gw - 1);
    endfunction

endpackage

// File: rtl/sig_mixer_if.sv
// Mixer control/data bundle.
//   master: drives sample_tick, gate, ch_en, ch_gain, noise_en, sig_in
//   slave : drives sig_out, sig_valid, busy, clip, overrun
interface sig_mixer_if #(
    parameter int unsigned NCH = 4,
    parameter int unsigned W   = 16,
    parameter int unsigned GW  = 4
);
    logic                sample_tick;
    logic                gate;
    logic [NCH-1:0]      ch_en;
    logic [NCH*GW-1:0]   ch_gain;
    logic                noise_en;
    logic [NCH*W-1:0]    sig_in;
    logic [W-1:0]        sig_out;
    logic                sig_valid;
    logic                busy;
    logic                clip;
    logic                overrun;

    modport master (
        output sample_tick, gate, ch_en, ch_gain, noise_en, sig_in,
        input  sig_out, sig_valid, busy, clip, overrun
    );

    modport slave (
        input  sample_tick, gate, ch_en, ch_gain, noise_en, sig_in,
        output sig_out, sig_valid, busy, clip, overrun
    );
endinterface

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR noise source; advances one step per cycle with step high.
//   clk, rst : clock, async active-high reset (loads LFSR_SEED)
//   step     : advance one position
//   q        : current LFSR state
module lfsr16
    import mixer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    output logic [15:0] q
);

    logic w_fb;

    assign w_fb = q[LFSR_TAP_A] ^ q[LFSR_TAP_B] ^ q[LFSR_TAP_C] ^ q[LFSR_TAP_D];

    // Seed is nonzero and the taps are maximal-length, so all-zero never occurs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= LFSR_SEED;
        end else if (step) begin
            q <= {q[14:0], w_fb};
        end
    end

endmodule

// File: rtl/sig_mixer.sv
// Time-multiplexed mixer: sums NCH gained oscillator channels plus an optional
// LFSR noise voice, one channel per clock, and saturates to W bits.
//   clk, rst : clock, async active-high reset
//   bus      : sig_mixer_if.slave (tick, gate, enables, gains, samples in;
//              sig_out, sig_valid, busy, clip, overrun out)
module sig_mixer
    import mixer_pkg::*;
#(
    parameter int unsigned NCH         = 4,
    parameter int unsigned W           = 16,
    parameter int unsigned GW          = 4,
    parameter int unsigned NOISE_SHIFT = 2
) (
    input  logic         clk,
    input  logic         rst,
    sig_mixer_if.slave   bus
);

    localparam int unsigned ACC_W  = W + $clog2(NCH + 1) + 1;
    localparam int unsigned PROD_W = W + GW;
    localparam int unsigned IDX_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned Q_FRAC = $clog2(unity_gain(GW));

    state_t              r_state;
    state_t              w_state_nxt;

    logic [NCH*W-1:0]    r_sig;
    logic [NCH*GW-1:0]   r_gain;
    logic [NCH-1:0]      r_en;
    logic                r_gate;
    logic                r_noise_en;
    logic [ACC_W-1:0]    r_acc;
    logic [IDX_W-1:0]    r_idx;

    logic [W-1:0]        r_sig_out;
    logic                r_sig_valid;
    logic                r_busy;
    logic                r_clip;
    logic                r_overrun;

    logic                w_accept;
    logic                w_lfsr_step;
    logic [15:0]         w_lfsr;
    logic [W-1:0]        w_cur_in;
    logic [GW-1:0]       w_cur_gain;
    logic [PROD_W-1:0]   w_prod;
    logic [ACC_W-1:0]    w_term;
    logic [ACC_W-1:0]    w_noise;
    logic [ACC_W-1:0]    w_sum;
    logic                w_sat;
    logic [W-1:0]        w_result;

    assign w_accept    = bus.sample_tick && (r_state == S_IDLE);
    assign w_lfsr_step = w_accept;

    lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .step (w_lfsr_step),
        .q    (w_lfsr)
    );

    // Single shared multiplier, fed by the channel selected by r_idx
    assign w_cur_in   = r_sig[r_idx*W +: W];
    assign w_cur_gain = r_gain[r_idx*GW +: GW];
    assign w_prod     = PROD_W'(w_cur_in) * PROD_W'(w_cur_gain);
    assign w_term     = r_en[r_idx] ? ACC_W'(w_prod >> Q_FRAC) : '0;

    // Noise add and saturation are folded into the NOISE cycle so the
    // registered result is visible in the OUT cycle
    assign w_noise  = r_noise_en ? ACC_W'(w_lfsr >> NOISE_SHIFT) : '0;
    assign w_sum    = r_acc + w_noise;
    assign w_sat    = w_sum > ACC_W'({W{1'b1}});
    assign w_result = !r_gate ? '0 : (w_sat ? '1 : w_sum[W-1:0]);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.sample_tick) w_state_nxt = S_ACCUM;
            S_ACCUM: if (r_idx == IDX_W'(NCH - 1)) w_state_nxt = S_NOISE;
            S_NOISE: w_state_nxt = S_OUT;
            S_OUT:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Snapshot, accumulate and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig       <= '0;
            r_gain      <= '0;
            r_en        <= '0;
            r_gate      <= 1'b0;
            r_noise_en  <= 1'b0;
            r_acc       <= '0;
            r_idx       <= '0;
            r_sig_out   <= '0;
            r_sig_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_clip      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_sig_valid <= 1'b0;
            r_busy      <= (w_state_nxt != S_IDLE);
            if (bus.sample_tick && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sig      <= bus.sig_in;
                        r_gain     <= bus.ch_gain;
                        r_en       <= bus.ch_en;
                        r_gate     <= bus.gate;
                        r_noise_en <= bus.noise_en;
                        r_acc      <= '0;
                        r_idx      <= '0;
                    end
                end
                S_ACCUM: begin
                    r_acc <= r_acc + w_term;
                    r_idx <= r_idx + IDX_W'(1);
                end
                S_NOISE: begin
                    r_acc       <= w_sum;
                    r_sig_out   <= w_result;
                    r_clip      <= r_gate & w_sat;
                    r_sig_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.sig_out   = r_sig_out;
    assign bus.sig_valid = r_sig_valid;
    assign bus.busy      = r_busy;
    assign bus.clip      = r_clip;
    assign bus.overrun   = r_overrun;

endmodule
